// File: rtl/rggen_axi4lite_bus_bridge.sv
// AXI4-Lite slave front end that turns one AXI transaction at a time into a
// register-bus request and returns the bus completion as a B or R response.
module rggen_axi4lite_bus_bridge #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32,
   parameter bit WRITE_FIRST   = 1'b1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_awvalid,
   output logic                       o_awready,
   input  logic [ADDRESS_WIDTH-1:0]   i_awaddr,
   input  logic [2:0]                 i_awprot,
   input  logic                       i_wvalid,
   output logic                       o_wready,
   input  logic [BUS_WIDTH-1:0]       i_wdata,
   input  logic [BUS_WIDTH/8-1:0]     i_wstrb,
   output logic                       o_bvalid,
   input  logic                       i_bready,
   output logic [1:0]                 o_bresp,
   input  logic                       i_arvalid,
   output logic                       o_arready,
   input  logic [ADDRESS_WIDTH-1:0]   i_araddr,
   input  logic [2:0]                 i_arprot,
   output logic                       o_rvalid,
   input  logic                       i_rready,
   output logic [BUS_WIDTH-1:0]       o_rdata,
   output logic [1:0]                 o_rresp,
   output logic                       o_bus_valid,
   output logic [1:0]                 o_bus_access,
   output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
   output logic [BUS_WIDTH-1:0]       o_bus_write_data,
   output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
   input  logic                       i_bus_ready,
   input  logic [1:0]                 i_bus_status,
   input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);

   localparam int STRB_WIDTH = BUS_WIDTH / 8;
   localparam int LSB        = $clog2(STRB_WIDTH);

   localparam logic [1:0] ACCESS_WRITE = 2'b01;
   localparam logic [1:0] ACCESS_READ  = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      BUS_ACCESS,
      WAIT_B,
      WAIT_R
   } state_e;

   state_e                   state;
   logic                     write_pending;
   logic                     read_pending;
   logic                     select_write;
   logic                     select_read;
   logic [ADDRESS_WIDTH-1:0] aw_aligned;
   logic [ADDRESS_WIDTH-1:0] ar_aligned;
   logic [1:0]               status;
   logic [BUS_WIDTH-1:0]     read_data;
   logic                     unused_inputs;

   // Handshakes: a transfer happens on a clock edge where valid and ready are
   // both high. Readies are only raised in IDLE and only for the selected
   // channel; AW and W are always accepted together so a write is never split.
   assign write_pending = i_awvalid && i_wvalid;
   assign read_pending  = i_arvalid;
   assign select_write  = (state == IDLE) && write_pending && (WRITE_FIRST || !read_pending);
   assign select_read   = (state == IDLE) && read_pending && (!WRITE_FIRST || !write_pending);

   assign o_awready = select_write;
   assign o_wready  = select_write;
   assign o_arready = select_read;

   assign aw_aligned = {i_awaddr[ADDRESS_WIDTH-1:LSB], {LSB{1'b0}}};
   assign ar_aligned = {i_araddr[ADDRESS_WIDTH-1:LSB], {LSB{1'b0}}};

   assign o_bresp = status;
   assign o_rresp = status;
   assign o_rdata = read_data;

   assign unused_inputs = ^{i_awprot, i_arprot, i_awaddr[LSB-1:0], i_araddr[LSB-1:0]};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state            <= IDLE;
         o_bus_valid      <= 1'b0;
         o_bus_access     <= 2'b00;
         o_bus_address    <= '0;
         o_bus_write_data <= '0;
         o_bus_strobe     <= '0;
         o_bvalid         <= 1'b0;
         o_rvalid         <= 1'b0;
         status           <= 2'b00;
         read_data        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (select_write) begin
                  state            <= BUS_ACCESS;
                  o_bus_valid      <= 1'b1;
                  o_bus_access     <= ACCESS_WRITE;
                  o_bus_address    <= aw_aligned;
                  o_bus_write_data <= i_wdata;
                  o_bus_strobe     <= i_wstrb;
               end else if (select_read) begin
                  state            <= BUS_ACCESS;
                  o_bus_valid      <= 1'b1;
                  o_bus_access     <= ACCESS_READ;
                  o_bus_address    <= ar_aligned;
                  o_bus_write_data <= '0;
                  o_bus_strobe     <= '1;
               end
            end
            BUS_ACCESS: begin
               if (i_bus_ready) begin
                  o_bus_valid <= 1'b0;
                  status      <= i_bus_status;
                  if (o_bus_access == ACCESS_WRITE) begin
                     state    <= WAIT_B;
                     o_bvalid <= 1'b1;
                  end else begin
                     state     <= WAIT_R;
                     o_rvalid  <= 1'b1;
                     read_data <= i_bus_read_data;
                  end
               end
            end
            WAIT_B: begin
               if (i_bready) begin
                  state    <= IDLE;
                  o_bvalid <= 1'b0;
               end
            end
            WAIT_R: begin
               // Read data is cleared with the handshake so o_rdata is 0 whenever o_rvalid is 0.
               if (i_rready) begin
                  state     <= IDLE;
                  o_rvalid  <= 1'b0;
                  read_data <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rggen_axi4lite_bus_bridge.sv
// Directed bench for rggen_axi4lite_bus_bridge; dut0 uses WRITE_FIRST=1 and
// dut1 uses WRITE_FIRST=0, sharing everything except the AXI request valids.
module tb_rggen_axi4lite_bus_bridge;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk;
   logic          rst_n;
   logic          awvalid, wvalid, arvalid;
   logic          awvalid_1, wvalid_1, arvalid_1;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          bready, rready;
   logic          bus_ready;
   logic [1:0]    bus_status;
   logic [DW-1:0] bus_read_data;

   logic          awready, wready, bvalid, arready, rvalid, bus_valid;
   logic [1:0]    bresp, rresp, bus_access;
   logic [DW-1:0] rdata, bus_write_data;
   logic [AW-1:0] bus_address;
   logic [SW-1:0] bus_strobe;

   logic          awready_1, wready_1, bvalid_1, arready_1, rvalid_1, bus_valid_1;
   logic [1:0]    bresp_1, rresp_1, bus_access_1;
   logic [DW-1:0] rdata_1, bus_write_data_1;
   logic [AW-1:0] bus_address_1;
   logic [SW-1:0] bus_strobe_1;

   int checks;
   int errors;

   rggen_axi4lite_bus_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .WRITE_FIRST(1'b1)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr), .i_awprot(3'b000),
      .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
      .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
      .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr), .i_arprot(3'b000),
      .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
      .o_bus_valid(bus_valid), .o_bus_access(bus_access), .o_bus_address(bus_address),
      .o_bus_write_data(bus_write_data), .o_bus_strobe(bus_strobe),
      .i_bus_ready(bus_ready), .i_bus_status(bus_status), .i_bus_read_data(bus_read_data)
   );

   rggen_axi4lite_bus_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .WRITE_FIRST(1'b0)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_awvalid(awvalid_1), .o_awready(awready_1), .i_awaddr(awaddr), .i_awprot(3'b000),
      .i_wvalid(wvalid_1), .o_wready(wready_1), .i_wdata(wdata), .i_wstrb(wstrb),
      .o_bvalid(bvalid_1), .i_bready(bready), .o_bresp(bresp_1),
      .i_arvalid(arvalid_1), .o_arready(arready_1), .i_araddr(araddr), .i_arprot(3'b000),
      .o_rvalid(rvalid_1), .i_rready(rready), .o_rdata(rdata_1), .o_rresp(rresp_1),
      .o_bus_valid(bus_valid_1), .o_bus_access(bus_access_1), .o_bus_address(bus_address_1),
      .o_bus_write_data(bus_write_data_1), .o_bus_strobe(bus_strobe_1),
      .i_bus_ready(bus_ready), .i_bus_status(bus_status), .i_bus_read_data(bus_read_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      awvalid = 0; wvalid = 0; arvalid = 0;
      awvalid_1 = 0; wvalid_1 = 0; arvalid_1 = 0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      bready = 0; rready = 0;
      bus_ready = 0; bus_status = 2'b00; bus_read_data = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      sample();
      check("rst_bus_valid", bus_valid, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_awready", awready, 0);
      check("rst_address", bus_address, 0);
      next_cycle();

      // single write, bus ready one cycle after bus valid
      awvalid = 1; wvalid = 1; awaddr = 8'h13; wdata = 32'hA5A5_0F0F; wstrb = 4'b0101;
      sample();
      check("wr_awready", awready, 1);
      check("wr_wready", wready, 1);
      check("wr_arready", arready, 0);
      next_cycle();
      awvalid = 0; wvalid = 0;
      sample();
      check("wr_bus_valid0", bus_valid, 1);
      check("wr_address", bus_address, 8'h10);
      check("wr_access", bus_access, 2'b01);
      check("wr_strobe", bus_strobe, 4'b0101);
      check("wr_wdata", bus_write_data, 32'hA5A5_0F0F);
      next_cycle();
      bus_ready = 1; bus_status = 2'b00;
      sample();
      check("wr_bus_valid1", bus_valid, 1);
      check("wr_bvalid_early", bvalid, 0);
      next_cycle();
      bus_ready = 0;
      sample();
      check("wr_bus_valid_drop", bus_valid, 0);
      check("wr_bvalid", bvalid, 1);
      check("wr_bresp", bresp, 2'b00);
      next_cycle();
      bready = 1;
      sample();
      check("wr_bvalid_hold", bvalid, 1);
      next_cycle();
      bready = 0;
      sample();
      check("wr_idle_bvalid", bvalid, 0);
      check("wr_idle_bus_valid", bus_valid, 0);
      next_cycle();

      // read with SLVERR, rready held low for three cycles
      arvalid = 1; araddr = 8'h24;
      sample();
      check("rd_arready", arready, 1);
      check("rd_awready", awready, 0);
      next_cycle();
      arvalid = 0; bus_ready = 1; bus_status = 2'b10; bus_read_data = 32'hDEAD_BEEF;
      sample();
      check("rd_bus_valid", bus_valid, 1);
      check("rd_access", bus_access, 2'b10);
      check("rd_address", bus_address, 8'h24);
      check("rd_strobe", bus_strobe, 4'hF);
      check("rd_wdata", bus_write_data, 0);
      next_cycle();
      bus_ready = 0; bus_status = 2'b00; bus_read_data = '0;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("rd_rvalid_hold", rvalid, 1);
         check("rd_rdata_hold", rdata, 32'hDEAD_BEEF);
         check("rd_rresp_hold", rresp, 2'b10);
         check("rd_bus_valid_off", bus_valid, 0);
         next_cycle();
      end
      rready = 1;
      sample();
      check("rd_rvalid_hs", rvalid, 1);
      next_cycle();
      rready = 0;
      sample();
      check("rd_rvalid_done", rvalid, 0);
      check("rd_rdata_zero", rdata, 0);
      next_cycle();

      // simultaneous requests on dut0 (write first)
      awvalid = 1; wvalid = 1; arvalid = 1; awaddr = 8'h08; araddr = 8'h0C;
      wdata = 32'h1122_3344; wstrb = 4'hF;
      sample();
      check("wf_awready", awready, 1);
      check("wf_arready", arready, 0);
      next_cycle();
      awvalid = 0; wvalid = 0; bus_ready = 1; bus_status = 2'b00;
      sample();
      check("wf_first_access", bus_access, 2'b01);
      check("wf_arready_busy", arready, 0);
      next_cycle();
      bus_ready = 0; bready = 1;
      sample();
      check("wf_bvalid", bvalid, 1);
      check("wf_arready_bhs", arready, 0);
      next_cycle();
      bready = 0;
      sample();
      check("wf_arready_after", arready, 1);
      next_cycle();
      arvalid = 0; bus_ready = 1; bus_read_data = 32'h0000_0055;
      sample();
      check("wf_second_access", bus_access, 2'b10);
      check("wf_second_addr", bus_address, 8'h0C);
      next_cycle();
      bus_ready = 0; rready = 1;
      sample();
      check("wf_rvalid", rvalid, 1);
      check("wf_rdata", rdata, 32'h55);
      next_cycle();
      rready = 0;
      sample();
      check("wf_rvalid_done", rvalid, 0);
      next_cycle();

      // simultaneous requests on dut1 (read first)
      awvalid_1 = 1; wvalid_1 = 1; arvalid_1 = 1; awaddr = 8'h18; araddr = 8'h1C;
      sample();
      check("rf_arready", arready_1, 1);
      check("rf_awready", awready_1, 0);
      check("rf_wready", wready_1, 0);
      next_cycle();
      arvalid_1 = 0; bus_ready = 1; bus_read_data = 32'h0000_0066;
      sample();
      check("rf_first_access", bus_access_1, 2'b10);
      check("rf_awready_busy", awready_1, 0);
      next_cycle();
      bus_ready = 0; rready = 1;
      sample();
      check("rf_rvalid", rvalid_1, 1);
      check("rf_rdata", rdata_1, 32'h66);
      check("rf_awready_rhs", awready_1, 0);
      next_cycle();
      rready = 0;
      sample();
      check("rf_awready_after", awready_1, 1);
      next_cycle();
      awvalid_1 = 0; wvalid_1 = 0; bus_ready = 1;
      sample();
      check("rf_second_access", bus_access_1, 2'b01);
      check("rf_second_addr", bus_address_1, 8'h18);
      check("rf_dut0_idle", bus_valid, 0);
      next_cycle();
      bus_ready = 0; bready = 1;
      sample();
      check("rf_bvalid", bvalid_1, 1);
      next_cycle();
      bready = 0;
      sample();
      check("rf_bvalid_done", bvalid_1, 0);
      next_cycle();

      // AW without W for four cycles, then W arrives
      awvalid = 1; wvalid = 0; awaddr = 8'h44; wdata = 32'hCAFE_0001; wstrb = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         sample();
         check("aw_only_awready", awready, 0);
         check("aw_only_bus_valid", bus_valid, 0);
         next_cycle();
      end
      wvalid = 1;
      sample();
      check("aw_w_awready", awready, 1);
      check("aw_w_wready", wready, 1);
      next_cycle();
      awvalid = 0; wvalid = 0; bus_ready = 1;
      sample();
      check("aw_w_bus_valid", bus_valid, 1);
      check("aw_w_address", bus_address, 8'h44);
      check("aw_w_strobe", bus_strobe, 4'b0011);
      next_cycle();
      bus_ready = 0; bready = 1;
      sample();
      check("aw_w_bvalid", bvalid, 1);
      next_cycle();
      bready = 0;

      // bus stall for ten cycles while other AXI requests arrive
      arvalid = 1; araddr = 8'h30;
      sample();
      check("stall_arready", arready, 1);
      next_cycle();
      awvalid = 1; wvalid = 1; arvalid = 1; awaddr = 8'h70; araddr = 8'h74;
      wdata = 32'h1234_5678; wstrb = 4'h1;
      for (int i = 0; i < 10; i++) begin
         sample();
         check("stall_bus_valid", bus_valid, 1);
         check("stall_address", bus_address, 8'h30);
         check("stall_access", bus_access, 2'b10);
         check("stall_strobe", bus_strobe, 4'hF);
         check("stall_wdata", bus_write_data, 0);
         check("stall_readies", {awready, wready, arready}, 3'b000);
         next_cycle();
      end
      awvalid = 0; wvalid = 0; arvalid = 0;
      bus_ready = 1; bus_status = 2'b11; bus_read_data = 32'h0000_0077;
      next_cycle();
      bus_ready = 0; rready = 1;
      sample();
      check("stall_rdata", rdata, 32'h77);
      check("stall_rresp", rresp, 2'b11);
      next_cycle();
      rready = 0;

      // reset asserted while in BUS_ACCESS
      awvalid = 1; wvalid = 1; awaddr = 8'h50; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      sample();
      check("mid_awready", awready, 1);
      next_cycle();
      awvalid = 0; wvalid = 0; bus_status = 2'b00;
      sample();
      check("mid_bus_valid", bus_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_bus_valid", bus_valid, 0);
      check("mid_rst_access", bus_access, 0);
      check("mid_rst_address", bus_address, 0);
      check("mid_rst_wdata", bus_write_data, 0);
      check("mid_rst_bvalid", bvalid, 0);
      next_cycle();
      rst_n = 1'b1;
      bus_ready = 1;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("post_rst_bvalid", bvalid, 0);
         check("post_rst_rvalid", rvalid, 0);
         check("post_rst_bus_valid", bus_valid, 0);
         next_cycle();
      end
      bus_ready = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
